hub75_bcm_driver: RTL and testbench

Parametrised HUB75 scan engine that replaces the fixed 96×48, 12-bit panel path with a single-clock driver of configurable geometry, colour depth and on-time. It reads pixels from a synchronous frame-buffer read port, shifts upper and lower half-rows into the chain and shows each colour bit-plane with binary-coded modulation (BCM). It sits between the frame-buffer RAM's read port and the panel connector, with optional double-buffered frame swap.

---
 rtl/hub75_bcm_driver.sv | 172 +++++++++++++++++
 tb/tb_hub75_bcm_driver.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_bcm_driver.sv
// HUB75 scan engine: shifts upper/lower half-rows from a synchronous frame buffer and shows each
// colour bit-plane with binary-coded modulation. Define HUB75_DOUBLE_BUFFER_EN for bank swapping.
module hub75_bcm_driver #(
   parameter int  WIDTH   = 96,
   parameter int  HEIGHT  = 48,
   parameter int  BPC     = 4,
   parameter int  BASE_ON = 8,
   localparam int ROW_W   = (HEIGHT > 2) ? $clog2(HEIGHT / 2) : 1,
   localparam int ADDR_W  = $clog2(WIDTH * HEIGHT) + 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_enable,
   input  logic              i_swap_req,
   output logic              o_swap_ack,
   output logic              o_bank,
   output logic              o_frame_start,
   output logic              fb_rd_en,
   output logic [ADDR_W-1:0] fb_addr,
   input  logic [3*BPC-1:0]  fb_data,
   output logic              sclk,
   output logic              lat,
   output logic              oe,
   output logic              r0,
   output logic              g0,
   output logic              b0,
   output logic              r1,
   output logic              g1,
   output logic              b1,
   output logic [ROW_W-1:0]  o_row_select
);
   localparam int HALF  = HEIGHT / 2;
   localparam int PIX_W = ADDR_W - 1;
   localparam int COL_W = $clog2(WIDTH);
   localparam int PL_W  = (BPC > 1) ? $clog2(BPC) : 1;
   localparam int CNT_W = $clog2(BASE_ON << (BPC - 1)) + 1;

   typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_TAIL, S_LATCH, S_DISPLAY} state_t;

   state_t            state, next_state;
   logic [COL_W-1:0]  col;
   logic [1:0]        phase;
   logic [ROW_W-1:0]  row;
   logic [PL_W-1:0]   plane;
   logic [CNT_W-1:0]  disp_cnt, on_len;
   logic [3*BPC-1:0]  top_word;
   logic [BPC-1:0]    top_r, top_g, top_b, bot_r, bot_g, bot_b;
   logic [PIX_W-1:0]  y_sel, pix_addr;
   logic              col_last, plane_last, row_last, disp_done, frame_end, bank;

   assign {top_r, top_g, top_b} = top_word;
   assign {bot_r, bot_g, bot_b} = fb_data;

   assign col_last   = (col == COL_W'(WIDTH - 1));
   assign plane_last = (plane == PL_W'(BPC - 1));
   assign row_last   = (row == ROW_W'(HALF - 1));
   assign on_len     = CNT_W'(BASE_ON) << plane;
   assign disp_done  = (disp_cnt == on_len - 1'b1);
   assign frame_end  = (state == S_DISPLAY) && disp_done && plane_last && row_last;

   // Phase 0 fetches the upper half pixel, phase 1 the lower half pixel of the same column.
   assign y_sel    = PIX_W'(row) + (phase[0] ? PIX_W'(HALF) : PIX_W'(0));
   assign pix_addr = y_sel * PIX_W'(WIDTH) + PIX_W'(col);
   assign fb_addr  = fb_rd_en ? {bank, pix_addr} : '0;

   assign o_frame_start = (state == S_SHIFT) && (col == '0) && (phase == 2'd0) &&
                          (row == '0) && (plane == '0);
   assign o_bank = bank;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= S_IDLE;
      else       state <= next_state;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      next_state = state;
      sclk       = 1'b0;
      lat        = 1'b0;
      oe         = 1'b1;
      fb_rd_en   = 1'b0;
      case (state)
         S_IDLE: if (i_enable) next_state = S_SHIFT;
         S_SHIFT: begin
            fb_rd_en = ~phase[1];
            sclk     = ~phase[1] && (col != '0);
            if (phase == 2'd3 && col_last) next_state = S_TAIL;
         end
         S_TAIL: begin
            sclk = 1'b1;
            if (phase == 2'd1) next_state = S_LATCH;
         end
         S_LATCH: begin
            lat        = 1'b1;
            next_state = S_DISPLAY;
         end
         S_DISPLAY: begin
            oe = 1'b0;
            if (disp_done) next_state = (frame_end && !i_enable) ? S_IDLE : S_SHIFT;
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         col                      <= '0;
         phase                    <= '0;
         row                      <= '0;
         plane                    <= '0;
         disp_cnt                 <= '0;
         top_word                 <= '0;
         {r0, g0, b0, r1, g1, b1} <= '0;
         o_row_select             <= '0;
      end else begin
         case (state)
            S_SHIFT: begin
               phase <= phase + 2'd1;
               if (phase == 2'd3) col <= col_last ? '0 : col + 1'b1;
               if (phase == 2'd1) top_word <= fb_data;
               if (phase == 2'd2) begin
                  r0 <= top_r[plane];
                  g0 <= top_g[plane];
                  b0 <= top_b[plane];
                  r1 <= bot_r[plane];
                  g1 <= bot_g[plane];
                  b1 <= bot_b[plane];
               end
            end
            S_TAIL:  phase <= (phase == 2'd1) ? 2'd0 : phase + 2'd1;
            S_LATCH: o_row_select <= row;
            S_DISPLAY: begin
               if (disp_done) begin
                  disp_cnt <= '0;
                  if (plane_last) begin
                     plane <= '0;
                     row   <= row_last ? '0 : row + 1'b1;
                  end else begin
                     plane <= plane + 1'b1;
                  end
               end else begin
                  disp_cnt <= disp_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef HUB75_DOUBLE_BUFFER_EN
   // The displayed bank only flips on the frame-end edge; the writer owns the other bank.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         bank       <= 1'b0;
         o_swap_ack <= 1'b0;
      end else begin
         o_swap_ack <= 1'b0;
         if (frame_end && i_swap_req) begin
            bank       <= ~bank;
            o_swap_ack <= 1'b1;
         end
      end
   end
`else
   logic unused_swap_req;
   assign unused_swap_req = i_swap_req;
   assign bank            = 1'b0;
   assign o_swap_ack      = 1'b0;
`endif

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Scoreboard bench for hub75_bcm_driver: a frame model queues the expected line records and an
// independent monitor reconstructs each line from the panel pins and compares it.
`timescale 1ns/1ps
module tb_hub75_bcm_driver;
   localparam int W         = 4;
   localparam int H         = 4;
   localparam int BPC       = 2;
   localparam int BASE_ON   = 2;
   localparam int HALF      = H / 2;
   localparam int AW        = 5;
   localparam int DW        = 3 * BPC;
   localparam int FRAME_CYC = HALF * (BPC * (4 * W + 3) + BASE_ON * ((1 << BPC) - 1));
`ifdef HUB75_DOUBLE_BUFFER_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif

   logic          i_clk = 1'b0;
   logic          i_rst, i_enable, i_swap_req;
   logic          o_swap_ack, o_bank, o_frame_start, fb_rd_en;
   logic [AW-1:0] fb_addr;
   logic [DW-1:0] fb_data = '0;
   logic          sclk, lat, oe, r0, g0, b0, r1, g1, b1;
   logic [0:0]    o_row_select;

   hub75_bcm_driver #(.WIDTH(W), .HEIGHT(H), .BPC(BPC), .BASE_ON(BASE_ON)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_swap_req(i_swap_req),
      .o_swap_ack(o_swap_ack), .o_bank(o_bank), .o_frame_start(o_frame_start),
      .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_data(fb_data),
      .sclk(sclk), .lat(lat), .oe(oe),
      .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
      .o_row_select(o_row_select)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [6*W-1:0]    data;
      logic [2*W*AW-1:0] addr;
      int                nrise;
      int                naddr;
      int                nlat;
      int                on;
      int                len;
      int                row;
      logic [1:0]        fs;
      logic              bank;
      logic              stable;
   } line_t;

   line_t         exp_q[$];
   logic [DW-1:0] mem [0:(1<<AW)-1];
   int            n_cmp = 0, n_err = 0, n_ack = 0, exp_acks = 0;
   bit            model_bank = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Synchronous frame-buffer read port, one cycle latency.
   initial forever begin
      @(posedge i_clk);
      if (fb_rd_en) fb_data <= mem[fb_addr];
   end

   function automatic logic plane_bit(input logic [DW-1:0] w, input int chan, input int p);
      logic [DW-1:0] s;
      s = w >> ((2 - chan) * BPC + p);
      return s[0];
   endfunction

   // Reference: what the panel should see for each (row, plane) line of a frame.
   task automatic push_frame(input bit bank, input int max_lines);
      int n = 0;
      for (int row = 0; row < HALF; row++) begin
         for (int p = 0; p < BPC; p++) begin
            line_t e;
            e.data = '0;
            e.addr = '0;
            for (int x = 0; x < W; x++) begin
               int            ta, ba;
               logic [DW-1:0] tw, bw;
               ta = int'(bank) * W * H + row * W + x;
               ba = int'(bank) * W * H + (row + HALF) * W + x;
               tw = mem[AW'(ta)];
               bw = mem[AW'(ba)];
               e.data = {e.data[6*W-7:0], plane_bit(tw, 0, p), plane_bit(tw, 1, p), plane_bit(tw, 2, p),
                         plane_bit(bw, 0, p), plane_bit(bw, 1, p), plane_bit(bw, 2, p)};
               e.addr = {e.addr[2*W*AW-2*AW-1:0], AW'(ta), AW'(ba)};
            end
            e.nrise  = W;
            e.naddr  = 2 * W;
            e.nlat   = 1;
            e.on     = BASE_ON << p;
            e.len    = 4 * W + 3 + e.on;
            e.row    = row;
            e.fs     = (row == 0 && p == 0) ? 2'b11 : 2'b00;
            e.bank   = bank;
            e.stable = 1'b1;
            if (n < max_lines) exp_q.push_back(e);
            n++;
         end
      end
   endtask

   // Monitor: rebuilds each line from the pins and checks it against the queue head.
   initial begin
      bit    in_line = 1'b0, seen_low = 1'b0, sclk_q = 1'b0, bank_q = 1'b0;
      line_t o, e;
      forever begin
         @(negedge i_clk);
         if (i_rst) begin
            in_line = 1'b0;
            sclk_q  = 1'b0;
            bank_q  = o_bank;
         end else begin
            if ((o_bank !== bank_q) || o_swap_ack)
               check("swap_ack_with_bank_change", {62'd0, o_swap_ack, o_bank !== bank_q}, 64'd3);
            if (o_swap_ack) n_ack++;
            if (in_line && seen_low && oe) begin
               in_line = 1'b0;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_line: line for row %0d with no queued expectation", o.row);
               end else begin
                  e = exp_q.pop_front();
                  check("line_data", 64'(o.data), 64'(e.data));
                  check("line_addr", 64'(o.addr), 64'(e.addr));
                  check("line_sclk_rises", 64'(o.nrise), 64'(e.nrise));
                  check("line_reads", 64'(o.naddr), 64'(e.naddr));
                  check("line_lat", 64'(o.nlat), 64'(e.nlat));
                  check("line_on_time", 64'(o.on), 64'(e.on));
                  check("line_cycles", 64'(o.len), 64'(e.len));
                  check("line_row_select", 64'(o.row), 64'(e.row));
                  check("line_frame_start", 64'(o.fs), 64'(e.fs));
                  check("line_bank", {62'd0, o.stable, o.bank}, {62'd0, e.stable, e.bank});
               end
            end
            if (!in_line && fb_rd_en) begin
               in_line  = 1'b1;
               seen_low = 1'b0;
               o        = '{default: 0};
               o.bank   = o_bank;
               o.stable = 1'b1;
            end
            if (in_line) begin
               o.len++;
               if (o_frame_start) begin
                  o.fs[1] = 1'b1;
                  if (o.len == 1) o.fs[0] = 1'b1;
               end
               if (o_bank !== o.bank) o.stable = 1'b0;
               if (fb_rd_en) begin
                  o.addr = {o.addr[2*W*AW-AW-1:0], fb_addr};
                  o.naddr++;
               end
               if (sclk && !sclk_q) begin
                  o.data = {o.data[6*W-7:0], r0, g0, b0, r1, g1, b1};
                  o.nrise++;
               end
               if (lat) o.nlat++;
               if (!oe) begin
                  if (!seen_low) o.row = int'(o_row_select);
                  seen_low = 1'b1;
                  o.on++;
               end
            end
            sclk_q = sclk;
            bank_q = o_bank;
         end
      end
   end

   task automatic check_idle(input string name, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge i_clk);
         check(name, {57'd0, oe, sclk, lat, fb_rd_en, o_frame_start, o_swap_ack, |fb_addr}, 64'h40);
      end
   endtask

   task automatic fill(input int mode);
      for (int a = 0; a < (1 << AW); a++)
         mem[a] = (mode == 0) ? DW'(0) : (mode == 1) ? DW'(6'h3F) : DW'($urandom_range(0, 63));
   endtask

   task automatic run_frames(input int k);
      int t, last, fs_seen;
      bit start_bank;
      start_bank = model_bank;
      for (int f = 0; f < k; f++) begin
         push_frame(model_bank, HALF * BPC);
         if (DB) begin
            model_bank = ~model_bank;
            exp_acks++;
         end
      end
      i_enable = 1'b1;
      t = 0; last = 0; fs_seen = 0;
      while (fs_seen < k && t < k * FRAME_CYC + 50) begin
         @(negedge i_clk);
         t++;
         if (o_frame_start) begin
            if (fs_seen == 0) check("first_shift_addr", 64'(fb_addr), 64'({start_bank, 4'd0}));
            else              check("frame_period", 64'(t - last), 64'(FRAME_CYC));
            last = t;
            fs_seen++;
         end
      end
      if (fs_seen < k) begin
         n_cmp++; n_err++;
         $display("FAIL frame_start_timeout: saw %0d of %0d frame starts", fs_seen, k);
      end
      repeat (30) @(negedge i_clk);
      i_enable = 1'b0;
      t = 0;
      while (exp_q.size() != 0 && t < 2 * FRAME_CYC) begin
         @(negedge i_clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL line_timeout: %0d expected lines never appeared", exp_q.size());
         exp_q.delete();
      end
      check_idle("idle_after_frames", 20);
   endtask

   initial begin
      int t;
      i_rst = 1'b1; i_enable = 1'b0; i_swap_req = 1'b0;
      fill(0);
      repeat (4) @(negedge i_clk);
      check("reset_outputs", {50'd0, oe, sclk, lat, fb_rd_en, o_frame_start, o_swap_ack, o_bank,
                              r0, g0, b0, r1, g1, b1, o_row_select}, 64'h2000);
      i_rst = 1'b0;
      check_idle("idle_disabled", 16);

      i_swap_req = 1'b1;
      fill(1);
      run_frames(2);

      fill(0);
      mem[14] = 6'b10_00_00;
      mem[30] = 6'b10_00_00;
      run_frames(1);

      fill(2);
      run_frames(3);

      // Reset while row 1 is being displayed: only the two row-0 lines ever complete.
      fill(2);
      push_frame(model_bank, BPC);
      i_enable = 1'b1;
      t = 0;
      while (!(oe === 1'b0 && o_row_select === 1'b1) && t < 2 * FRAME_CYC) begin
         @(negedge i_clk);
         t++;
      end
      check("reached_row1_display", {62'd0, oe, o_row_select}, 64'h1);
      #2 i_rst = 1'b1;
      #1 check("async_reset_outputs", {45'd0, oe, sclk, lat, fb_rd_en, o_frame_start, o_swap_ack, o_bank,
                                      r0, g0, b0, r1, g1, b1, o_row_select, fb_addr}, 64'h40000);
      i_enable = 1'b0;
      @(negedge i_clk);
      check("partial_frame_lines", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      model_bank = 1'b0;
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;

      fill(2);
      run_frames(1);
      i_swap_req = 1'b0;

      check("swap_ack_count", 64'(n_ack), 64'(exp_acks));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
